// File: rtl/gbl_timer_ctrl.sv
// Timestamp-clear controller in the PCIe reference clock domain: stretches a
// one-cycle clear request into a timed clear level, gates the interval enable
// and clamps the interval length for the global timer.
module gbl_timer_ctrl #(
  parameter int unsigned HOLD_CYC     = 16,
  parameter int unsigned DRAIN_CYC    = 8,
  parameter logic [39:0] MIN_INTERVAL = 40'd4
) (
  input  logic        iCLK_PCIE_REF,
  input  logic        iRST_PCIE_REF_n,
  input  logic        iREG_TS_CLEAR,
  input  logic        iREG_CLEAR_RESTARTS_INTERVAL,
  input  logic        iREG_STATSINTERVAL_ENABLE,
  input  logic [39:0] iREG_STATSINTERVAL_CLOCKS,
  output logic        oRST_GLB_TIMESTAMP,
  output logic        oSTATSINTERVAL_ENABLE,
  output logic [39:0] oSTATSINTERVAL_CLOCKS,
  output logic        oTS_CLEAR_BUSY,
  output logic [15:0] oTS_CLEAR_COUNT
);

  localparam int unsigned MAX_CYC = (HOLD_CYC > DRAIN_CYC) ? HOLD_CYC : DRAIN_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_done;
  logic             r_rst_ts;
  logic             r_busy;
  logic             r_int_en;
  logic [39:0]      r_int_clocks;
  logic [15:0]      r_clear_count;

  logic             w_busy_now;
  assign w_busy_now = (r_state != S_IDLE);

  // Clear sequencer plus all registered outputs.
  always_ff @(posedge iCLK_PCIE_REF or negedge iRST_PCIE_REF_n) begin
    if (!iRST_PCIE_REF_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_done        <= 1'b0;
      r_rst_ts      <= 1'b0;
      r_busy        <= 1'b0;
      r_int_en      <= 1'b0;
      r_int_clocks  <= MIN_INTERVAL;
      r_clear_count <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iREG_TS_CLEAR) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
          end
        end
        S_HOLD: begin
          if (iREG_TS_CLEAR) r_pend <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_DRAIN;
            r_cnt   <= DRAIN_LD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_done <= 1'b1;
            // A pending or same-cycle request chains straight into the next hold.
            if (r_pend || iREG_TS_CLEAR) begin
              r_state <= S_HOLD;
              r_cnt   <= HOLD_LD;
              r_pend  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (iREG_TS_CLEAR) r_pend <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_done && (r_clear_count != 16'hFFFF))
        r_clear_count <= r_clear_count + 16'd1;

      r_rst_ts     <= (r_state == S_HOLD);
      r_busy       <= w_busy_now;
      r_int_en     <= iREG_STATSINTERVAL_ENABLE &
                      ~(iREG_CLEAR_RESTARTS_INTERVAL & w_busy_now);
      r_int_clocks <= (iREG_STATSINTERVAL_CLOCKS < MIN_INTERVAL) ?
                      MIN_INTERVAL : iREG_STATSINTERVAL_CLOCKS;
    end
  end

  assign oRST_GLB_TIMESTAMP    = r_rst_ts;
  assign oTS_CLEAR_BUSY        = r_busy;
  assign oSTATSINTERVAL_ENABLE = r_int_en;
  assign oSTATSINTERVAL_CLOCKS = r_int_clocks;
  assign oTS_CLEAR_COUNT       = r_clear_count;

endmodule
